// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Run/halt/single-step controller for the 8-bit CPU clock.
//               A free-running period counter counts 0..div and toggles
//               div_clk_o on every wrap. One CPU clock-enable pulse (cpu_ce)
//               is issued per divided period while running or stepping.
//               The divide value is changed through a cfg_req/cfg_ack
//               handshake and is applied only at a safe boundary:
//               immediately when idle, on a counter wrap otherwise.
//
// Ports       :
//   clk        in   1       system clock, all logic on rising edge
//   reset      in   1       asynchronous, active-low reset
//   run        in   1       level: enter/stay in RUN
//   halt       in   1       level: force IDLE (highest priority)
//   step_req   in   1       pulse: start stepping step_cnt CPU cycles (IDLE)
//   step_cnt   in   STEP_W  CPU cycles to step, sampled with step_req
//   cfg_req    in   1       divide-value change request, held until cfg_ack
//   cfg_div    in   CNT_W   new divide value, stable while cfg_req is high
//   cfg_ack    out  1       one-cycle pulse: cfg_div has been loaded
//   cpu_ce     out  1       one-cycle CPU clock enable
//   div_clk_o  out  1       divided clock level (monitoring/LED)
//   state_o    out  2       00 IDLE, 01 RUN, 10 STEP
//   busy       out  1       state_o != IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int          CNT_W   = 32,
    parameter int          STEP_W  = 8,
    parameter int unsigned DEF_DIV = 49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              halt,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic              cfg_req,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cpu_ce,
    output logic              div_clk_o,
    output logic [1:0]        state_o,
    output logic              busy
);

    // ------------------------------------------------------------------------
    // State encoding (matches the state_o output encoding directly)
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_RUN  = 2'b01;
    localparam logic [1:0] c_ST_STEP = 2'b10;

    localparam logic [CNT_W-1:0]  c_DEF_DIV  = CNT_W'(DEF_DIV);
    localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_div;
    logic              r_div_clk;
    logic              r_cpu_ce;
    logic              r_cfg_ack;
    logic [1:0]        r_state;
    logic [STEP_W-1:0] r_steps_left;
    logic              r_busy;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic              w_wrap;
    logic              w_active;
    logic              w_ce_edge;
    logic              w_ce_next;
    logic              w_cfg_load;
    logic [1:0]        w_state_nxt;
    logic [STEP_W-1:0] w_steps_nxt;

    // Wrap is judged against the divide value currently in force, so a
    // period that coincides with a config load still completes (and issues
    // its CE) with the old value.
    assign w_wrap   = (r_cnt == r_div);
    assign w_active = (r_state == c_ST_RUN) || (r_state == c_ST_STEP);

    // A CE-generating edge closes the low half of the divided clock. Halt
    // at that same edge suppresses the pulse but the edge is still the one
    // that would have stepped.
    assign w_ce_edge = w_wrap && !r_div_clk && w_active;
    assign w_ce_next = w_ce_edge && !halt;

    // Loads happen at once when idle and only on a wrap otherwise. Masking
    // with the previous ack keeps acks at least one cycle apart, giving the
    // requester a cycle to drop cfg_req.
    assign w_cfg_load = cfg_req && !r_cfg_ack &&
                        ((r_state == c_ST_IDLE) || w_wrap);

    // ------------------------------------------------------------------------
    // Next-state logic (priority: halt > run > step_req)
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_steps_nxt = r_steps_left;

        case (r_state)
            c_ST_IDLE: begin
                if (halt) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (run) begin
                    w_state_nxt = c_ST_RUN;
                end else if (step_req && (step_cnt != '0)) begin
                    w_state_nxt = c_ST_STEP;
                    w_steps_nxt = step_cnt;
                end
            end

            c_ST_RUN: begin
                // run is an entry condition only; dropping it keeps RUN.
                if (halt) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end

            c_ST_STEP: begin
                if (halt) begin
                    w_state_nxt = c_ST_IDLE;
                    w_steps_nxt = '0;
                end else if (run) begin
                    w_state_nxt = c_ST_RUN;
                    w_steps_nxt = '0;
                end else if (w_ce_edge) begin
                    w_steps_nxt = r_steps_left - c_STEP_ONE;
                    // Leave on the edge that issues the final CE so that
                    // exactly step_cnt pulses are produced.
                    if (r_steps_left == c_STEP_ONE) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
                w_steps_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and step counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_steps_left <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_steps_left <= w_steps_nxt;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
        end
    end

    // ------------------------------------------------------------------------
    // Period counter, divided clock and divide-value register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_div     <= c_DEF_DIV;
            r_div_clk <= 1'b1;
        end else begin
            // A load restarts the period from zero even off a wrap (idle
            // loads), so the new period starts cleanly.
            if (w_wrap || w_cfg_load) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_wrap) begin
                r_div_clk <= ~r_div_clk;
            end

            if (w_cfg_load) begin
                r_div <= cfg_div;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered pulse outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_ce  <= 1'b0;
            r_cfg_ack <= 1'b0;
        end else begin
            r_cpu_ce  <= w_ce_next;
            r_cfg_ack <= w_cfg_load;
        end
    end

    assign cpu_ce    = r_cpu_ce;
    assign cfg_ack   = r_cfg_ack;
    assign div_clk_o = r_div_clk;
    assign state_o   = r_state;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_ctrl
// Description : Self-checking bench for clk_div_ctrl with DEF_DIV=3. Expected
//               cpu_ce / cfg_ack edge numbers (counted from reset release)
//               are queued as stimulus is applied and popped by a monitor
//               whenever the DUT pulses the corresponding output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ctrl;

    localparam int CNT_W  = 32;
    localparam int STEP_W = 8;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              run      = 1'b0;
    logic              halt     = 1'b0;
    logic              step_req = 1'b0;
    logic [STEP_W-1:0] step_cnt = '0;
    logic              cfg_req  = 1'b0;
    logic [CNT_W-1:0]  cfg_div  = '0;
    logic              cfg_ack;
    logic              cpu_ce;
    logic              div_clk_o;
    logic [1:0]        state_o;
    logic              busy;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int base   = 0;
    int ce_q[$];
    int ack_q[$];

    clk_div_ctrl #(
        .CNT_W   (CNT_W),
        .STEP_W  (STEP_W),
        .DEF_DIV (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .halt      (halt),
        .step_req  (step_req),
        .step_cnt  (step_cnt),
        .cfg_req   (cfg_req),
        .cfg_div   (cfg_div),
        .cfg_ack   (cfg_ack),
        .cpu_ce    (cpu_ce),
        .div_clk_o (div_clk_o),
        .state_o   (state_o),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Scoreboard monitor: every pulse must match the head of its queue.
    always @(negedge clk) begin : b_mon
        int exp_e;
        if (cpu_ce === 1'b1) begin
            checks++;
            if (ce_q.size() == 0) begin
                errors++;
                $display("FAIL ce_unexpected: cpu_ce at edge %0d, none expected", edge_n - base);
            end else begin
                exp_e = ce_q.pop_front();
                if ((edge_n - base) !== exp_e) begin
                    errors++;
                    $display("FAIL ce_timing: cpu_ce at edge %0d, expected edge %0d", edge_n - base, exp_e);
                end
            end
        end
        if (cfg_ack === 1'b1) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: cfg_ack at edge %0d, none expected", edge_n - base);
            end else begin
                exp_e = ack_q.pop_front();
                if ((edge_n - base) !== exp_e) begin
                    errors++;
                    $display("FAIL ack_timing: cfg_ack at edge %0d, expected edge %0d", edge_n - base, exp_e);
                end
            end
        end
    end

    task automatic wait_rel(input int rel);
        while ((edge_n - base) < rel) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        run = 1'b0; halt = 1'b0; step_req = 1'b0; cfg_req = 1'b0;
        step_cnt = '0; cfg_div = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base  = edge_n;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL rst_ce: cpu_ce=%b expected 0", cpu_ce); end
        checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: cfg_ack=%b expected 0", cfg_ack); end
        checks++; if (div_clk_o !== 1'b1) begin errors++; $display("FAIL rst_divclk: div_clk_o=%b expected 1", div_clk_o); end
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL rst_state: state_o=%b expected 00", state_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%b expected 0", busy); end
    endtask

    task automatic test_run();
        apply_reset();
        ce_q.push_back(8); ce_q.push_back(16); ce_q.push_back(24);
        run = 1'b1;
        wait_rel(1);
        run = 1'b0;
        checks++; if (state_o !== 2'b01 || busy !== 1'b1) begin errors++; $display("FAIL run_enter: state_o=%b busy=%b expected 01/1", state_o, busy); end
        wait_rel(4);
        checks++; if (div_clk_o !== 1'b0) begin errors++; $display("FAIL run_div4: div_clk_o=%b expected 0", div_clk_o); end
        wait_rel(8);
        checks++; if (div_clk_o !== 1'b1) begin errors++; $display("FAIL run_div8: div_clk_o=%b expected 1", div_clk_o); end
        wait_rel(12);
        checks++; if (div_clk_o !== 1'b0) begin errors++; $display("FAIL run_div12: div_clk_o=%b expected 0", div_clk_o); end
        wait_rel(26);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL run_hold: state_o=%b expected 01", state_o); end
        checks++; if (ce_q.size() != 0) begin errors++; $display("FAIL run_drain: %0d CE pulses missing, expected 0", ce_q.size()); ce_q.delete(); end
        halt = 1'b1;
        wait_rel(27);
        halt = 1'b0;
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL run_halt: state_o=%b expected 00", state_o); end
    endtask

    task automatic test_step();
        apply_reset();
        ce_q.push_back(8); ce_q.push_back(16); ce_q.push_back(24);
        step_cnt = 8'd3; step_req = 1'b1;
        wait_rel(1);
        step_req = 1'b0; step_cnt = '0;
        checks++; if (state_o !== 2'b10 || busy !== 1'b1) begin errors++; $display("FAIL step_enter: state_o=%b busy=%b expected 10/1", state_o, busy); end
        wait_rel(23);
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL step_mid: state_o=%b expected 10", state_o); end
        wait_rel(24);
        checks++; if (state_o !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL step_done: state_o=%b busy=%b expected 00/0", state_o, busy); end
        wait_rel(34);
        checks++; if (ce_q.size() != 0) begin errors++; $display("FAIL step_drain: %0d CE pulses missing, expected 0", ce_q.size()); ce_q.delete(); end
        step_cnt = '0; step_req = 1'b1;
        wait_rel(35);
        step_req = 1'b0;
        checks++; if (state_o !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL step_zero: state_o=%b busy=%b expected 00/0", state_o, busy); end
        wait_rel(50);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL step_zero_hold: state_o=%b expected 00", state_o); end
    endtask

    task automatic test_cfg_run();
        int n;
        apply_reset();
        ce_q.push_back(8); ce_q.push_back(14); ce_q.push_back(18); ce_q.push_back(22);
        ack_q.push_back(12);
        run = 1'b1;
        wait_rel(1);
        run = 1'b0;
        wait_rel(10);
        cfg_div = 32'd1; cfg_req = 1'b1;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL cfgrun_ack1_timeout: cfg_ack=%b expected 1", cfg_ack); end
        cfg_req = 1'b0;
        wait_rel(23);
        ce_q.push_back(25); ce_q.push_back(27); ce_q.push_back(29); ce_q.push_back(31);
        ack_q.push_back(24);
        cfg_div = 32'd0; cfg_req = 1'b1;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL cfgrun_ack0_timeout: cfg_ack=%b expected 1", cfg_ack); end
        cfg_req = 1'b0;
        wait_rel(32);
        halt = 1'b1;
        wait_rel(33);
        halt = 1'b0;
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL cfgrun_halt: state_o=%b expected 00", state_o); end
        wait_rel(40);
        checks++; if (ce_q.size() != 0 || ack_q.size() != 0) begin errors++; $display("FAIL cfgrun_drain: %0d CE, %0d ack missing, expected 0", ce_q.size(), ack_q.size()); ce_q.delete(); ack_q.delete(); end
    endtask

    task automatic test_halt_step();
        apply_reset();
        ce_q.push_back(8);
        step_cnt = 8'd3; step_req = 1'b1;
        wait_rel(1);
        step_req = 1'b0; step_cnt = '0;
        wait_rel(15);
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL hstep_pre: state_o=%b expected 10", state_o); end
        halt = 1'b1;
        wait_rel(16);
        halt = 1'b0;
        checks++; if (state_o !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL hstep_halt: state_o=%b busy=%b expected 00/0", state_o, busy); end
        wait_rel(40);
        run = 1'b1; halt = 1'b1;
        wait_rel(41);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL hstep_runhalt1: state_o=%b expected 00", state_o); end
        wait_rel(42);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL hstep_runhalt2: state_o=%b expected 00", state_o); end
        run = 1'b0; halt = 1'b0;
        wait_rel(50);
        ce_q.push_back(56);
        step_cnt = 8'd1; step_req = 1'b1;
        wait_rel(51);
        step_req = 1'b0; step_cnt = '0;
        wait_rel(66);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL hstep_one: state_o=%b expected 00", state_o); end
        checks++; if (ce_q.size() != 0) begin errors++; $display("FAIL hstep_drain: %0d CE pulses missing, expected 0", ce_q.size()); ce_q.delete(); end
    endtask

    task automatic test_cfg_idle();
        int n;
        apply_reset();
        wait_rel(2);
        ack_q.push_back(3);
        cfg_div = 32'd5; cfg_req = 1'b1;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL cfgidle_ack_timeout: cfg_ack=%b expected 1", cfg_ack); end
        cfg_req = 1'b0;
        wait_rel(8);
        checks++; if (div_clk_o !== 1'b1) begin errors++; $display("FAIL cfgidle_div8: div_clk_o=%b expected 1", div_clk_o); end
        wait_rel(9);
        checks++; if (div_clk_o !== 1'b0) begin errors++; $display("FAIL cfgidle_div9: div_clk_o=%b expected 0", div_clk_o); end
        wait_rel(14);
        checks++; if (div_clk_o !== 1'b0) begin errors++; $display("FAIL cfgidle_div14: div_clk_o=%b expected 0", div_clk_o); end
        wait_rel(15);
        checks++; if (div_clk_o !== 1'b1) begin errors++; $display("FAIL cfgidle_div15: div_clk_o=%b expected 1", div_clk_o); end
        wait_rel(16);
        ce_q.push_back(27); ce_q.push_back(39);
        run = 1'b1;
        wait_rel(17);
        run = 1'b0;
        wait_rel(40);
        halt = 1'b1;
        wait_rel(41);
        halt = 1'b0;
        wait_rel(54);
        checks++; if (ce_q.size() != 0 || ack_q.size() != 0) begin errors++; $display("FAIL cfgidle_drain: %0d CE, %0d ack missing, expected 0", ce_q.size(), ack_q.size()); ce_q.delete(); ack_q.delete(); end
    endtask

    task automatic test_async_reset();
        int n;
        apply_reset();
        ce_q.push_back(8);
        run = 1'b1;
        wait_rel(1);
        run = 1'b0;
        wait_rel(12);
        checks++; if (state_o !== 2'b01 || div_clk_o !== 1'b0) begin errors++; $display("FAIL arst_pre: state_o=%b div_clk_o=%b expected 01/0", state_o, div_clk_o); end
        cfg_div = 32'd1; cfg_req = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++; if (cpu_ce !== 1'b0 || cfg_ack !== 1'b0) begin errors++; $display("FAIL arst_pulses: cpu_ce=%b cfg_ack=%b expected 0/0", cpu_ce, cfg_ack); end
        checks++; if (div_clk_o !== 1'b1) begin errors++; $display("FAIL arst_divclk: div_clk_o=%b expected 1", div_clk_o); end
        checks++; if (state_o !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL arst_state: state_o=%b busy=%b expected 00/0", state_o, busy); end
        repeat (2) @(negedge clk);
        checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL arst_noack: cfg_ack=%b expected 0", cfg_ack); end
        reset = 1'b1;
        base  = edge_n;
        ack_q.push_back(1);
        ce_q.push_back(5); ce_q.push_back(9);
        n = 0;
        while (cfg_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (cfg_ack !== 1'b1) begin errors++; $display("FAIL arst_ack_timeout: cfg_ack=%b expected 1", cfg_ack); end
        cfg_req = 1'b0;
        run = 1'b1;
        wait_rel(2);
        run = 1'b0;
        wait_rel(10);
        halt = 1'b1;
        wait_rel(11);
        halt = 1'b0;
        wait_rel(16);
        checks++; if (ce_q.size() != 0 || ack_q.size() != 0) begin errors++; $display("FAIL arst_drain: %0d CE, %0d ack missing, expected 0", ce_q.size(), ack_q.size()); ce_q.delete(); ack_q.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_run();
        test_step();
        test_cfg_run();
        test_halt_step();
        test_cfg_idle();
        test_async_reset();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
